// File: rtl/cmd_to_bus.sv
// Byte-stream command parser that masters the basil register bus and
// returns read data as a byte stream.
module cmd_to_bus #(
  parameter int unsigned ABUSWIDTH = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [7:0]           CMD_DATA,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  output logic [7:0]           RSP_DATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [ABUSWIDTH-1:0] BUS_ADD,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic [7:0]           BUS_DATA_IN,
  output logic                 BUS_RD,
  output logic                 BUS_WR,
  output logic                 BUSY,
  output logic [7:0]           ERR_CNT
);

  localparam int unsigned NBYTES = ABUSWIDTH / 8;
  localparam logic [1:0] LAST_ABYTE = 2'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_ADDR,
    S_WR_DATA,
    S_RD_STROBE,
    S_RD_WAIT,
    S_RD_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic                   is_read_q, is_read_d;
  logic                   fixed_q, fixed_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [1:0]             abyte_q, abyte_d;
  logic [ABUSWIDTH-1:0]   addr_q, addr_d;
  logic [7:0]             rsp_data_q, rsp_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [ABUSWIDTH-1:0]   bus_add_q, bus_add_d;
  logic [7:0]             bus_data_q, bus_data_d;
  logic                   bus_rd_q, bus_rd_d;
  logic                   bus_wr_q, bus_wr_d;
  logic                   busy_q, busy_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   cmd_ready_q, cmd_ready_d;

  logic                   cmd_fire;
  logic                   rsp_fire;
  logic [ABUSWIDTH-1:0]   addr_shift;
  logic [ABUSWIDTH-1:0]   addr_next;

  assign cmd_fire   = CMD_VALID & cmd_ready_q;
  assign rsp_fire   = rsp_valid_q & RSP_READY;
  assign addr_shift = (addr_q << 8) | ABUSWIDTH'(CMD_DATA);
  assign addr_next  = fixed_q ? addr_q : addr_q + ABUSWIDTH'(1);

  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    fixed_d     = fixed_q;
    cnt_d       = cnt_q;
    abyte_d     = abyte_q;
    addr_d      = addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    err_cnt_d   = err_cnt_q;
    // Bus outputs idle at zero so downstream decoders never see a stray match.
    bus_add_d   = '0;
    bus_data_d  = '0;
    bus_rd_d    = 1'b0;
    bus_wr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (CMD_DATA[7:2] != '0) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            is_read_d = CMD_DATA[0];
            fixed_d   = CMD_DATA[1];
            state_d   = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (cmd_fire) begin
          cnt_d   = (CMD_DATA == 8'd0) ? 9'd256 : {1'b0, CMD_DATA};
          abyte_d = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cmd_fire) begin
          addr_d  = addr_shift;
          abyte_d = abyte_q + 2'd1;
          if (abyte_q == LAST_ABYTE) begin
            if (is_read_q) begin
              bus_rd_d  = 1'b1;
              bus_add_d = addr_shift;
              state_d   = S_RD_STROBE;
            end else begin
              state_d = S_WR_DATA;
            end
          end
        end
      end
      S_WR_DATA: begin
        if (cmd_fire) begin
          bus_wr_d   = 1'b1;
          bus_add_d  = addr_q;
          bus_data_d = CMD_DATA;
          addr_d     = addr_next;
          cnt_d      = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = S_IDLE;
        end
      end
      S_RD_STROBE: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rsp_data_d  = BUS_DATA_IN;
        rsp_valid_d = 1'b1;
        state_d     = S_RD_OUT;
      end
      S_RD_OUT: begin
        // The next strobe is issued from the handshake edge itself, giving a
        // 3-cycle read turnaround.
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_IDLE;
          end else begin
            addr_d    = addr_next;
            bus_rd_d  = 1'b1;
            bus_add_d = addr_next;
            state_d   = S_RD_STROBE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_LEN) ||
                  (state_d == S_ADDR) || (state_d == S_WR_DATA);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q     <= S_IDLE;
      is_read_q   <= 1'b0;
      fixed_q     <= 1'b0;
      cnt_q       <= '0;
      abyte_q     <= '0;
      addr_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      bus_add_q   <= '0;
      bus_data_q  <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      fixed_q     <= fixed_d;
      cnt_q       <= cnt_d;
      abyte_q     <= abyte_d;
      addr_q      <= addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      bus_add_q   <= bus_add_d;
      bus_data_q  <= bus_data_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign CMD_READY    = cmd_ready_q;
  assign RSP_DATA     = rsp_data_q;
  assign RSP_VALID    = rsp_valid_q;
  assign BUS_ADD      = bus_add_q;
  assign BUS_DATA_OUT = bus_data_q;
  assign BUS_RD       = bus_rd_q;
  assign BUS_WR       = bus_wr_q;
  assign BUSY         = busy_q;
  assign ERR_CNT      = err_cnt_q;

endmodule

// File: doc/cmd_to_bus.md
# cmd_to_bus

Byte-stream bus initiator: parses a command stream (opcode, length, address, optional write data) and drives the basil register bus (BUS_RD/BUS_WR/BUS_ADD/BUS_DATA) as master, returning read data as a byte stream. It sits between a host link (UART/FTDI/Ethernet byte FIFO) and the bus decoders of all IP blocks, which see it as the single bus owner.

## Interface
- ABUSWIDTH, 16, bus address width; multiple of 8, 8..32.
- Data width is fixed at 8 bits.

- BUS_CLK  in  1  single clock for all logic.
- BUS_RST  in  1  asynchronous, active-high reset.
- CMD_DATA  in  8  command stream byte.
- CMD_VALID  in  1  CMD_DATA valid.
- CMD_READY  out  1  block accepts CMD_DATA; transfer when VALID&READY at rising edge.
- RSP_DATA  out  8  read data byte.
- RSP_VALID  out  1  RSP_DATA valid; held with data stable until accepted.
- RSP_READY  in  1  sink accepts RSP_DATA.
- BUS_ADD  out  ABUSWIDTH  bus address.
- BUS_DATA_OUT  out  8  write data to IPs.
- BUS_DATA_IN  in  8  read data from IPs (OR/mux of IP outputs).
- BUS_RD  out  1  one-cycle read strobe.
- BUS_WR  out  1  one-cycle write strobe.
- BUSY  out  1  high in any state except IDLE.
- ERR_CNT  out  8  saturating count of rejected opcodes.

## Operation
- Command: OPCODE, LEN, then ABUSWIDTH/8 address bytes MSB first; write commands add LEN data bytes.
- OPCODE bit0: 1 = read, 0 = write. Bit1: 1 = fixed address (FIFO port), 0 = increment. Bits[7:2] nonzero: byte dropped, ERR_CNT +1 (saturates at 255), stay IDLE.
- LEN = 0 means 256 transfers.
- Address increments by 1 per transfer modulo 2^ABUSWIDTH (0xFFFF wraps to 0x0000 for 16 bits).
- States: IDLE -> LEN -> ADDR (byte counter) -> WR_DATA (write) or RD_STROBE -> RD_WAIT -> RD_OUT (read) -> IDLE after last transfer.
- WR_DATA: each accepted byte produces one BUS_WR cycle with current address and that byte.
- Read: BUS_RD pulse, capture BUS_DATA_IN one cycle later, present on RSP; next BUS_RD only after RSP handshake.
- CMD_READY = 1 in IDLE, LEN, ADDR, WR_DATA; 0 in all read states.
- All bus outputs registered. When no strobe is active: BUS_ADD = 0, BUS_DATA_OUT = 0 (prevents stray decode in downstream decoders).
- Reset (any time, incl. mid-command or mid-read): return to IDLE, partial command discarded, pending RSP byte dropped, ERR_CNT cleared.

## Timing
- Reset values: CMD_READY 0 while BUS_RST high, 1 from the first cycle after release; RSP_VALID 0, RSP_DATA 0, BUS_RD 0, BUS_WR 0, BUS_ADD 0, BUS_DATA_OUT 0, BUSY 0, ERR_CNT 0.
- Write: data byte accepted at edge k -> BUS_WR, BUS_ADD, BUS_DATA_OUT valid in cycle k+1 for exactly one cycle. Back-to-back bytes give back-to-back BUS_WR cycles (1 per clock).
- Last write byte at edge k: state is IDLE from k, so the next OPCODE may be accepted at edge k+1 while BUS_WR of the last byte is high.
- Read: last address byte accepted at edge k -> BUS_RD high in cycle k+1; BUS_DATA_IN sampled at end of cycle k+2; RSP_VALID high from cycle k+3.
- RSP handshake at edge d -> RSP_VALID low in cycle d+1, next BUS_RD in cycle d+1. Peak read rate is 1 byte per 3 cycles.
- BUS_RD and BUS_WR are never high in the same cycle.
- RSP_READY held low: RSP_VALID and RSP_DATA stay stable indefinitely; no further BUS_RD is issued.
- BUSY rises the cycle after OPCODE acceptance and falls the cycle after the final transfer completes (final BUS_WR issued, or final RSP handshake).

## Test plan
- Write burst: 00 03 12 34 AA BB CC, CMD_VALID continuous -> BUS_WR in 3 consecutive cycles at 0x1234/AA, 0x1235/BB, 0x1236/CC; BUS_ADD = 0 before and after.
- Read burst, RSP_READY tied 1, model IP returns addr[7:0] one cycle after BUS_RD: 01 02 00 10 -> RSP bytes 10, 11; BUS_RD spacing exactly 3 cycles; BUSY low after the second handshake.
- Fixed-address read with RSP_READY low for 20 cycles: 03 04 40 00 -> single BUS_RD at 0x4000, RSP_DATA held stable, four BUS_RD total, all at 0x4000.
- Wrap and LEN=0: 00 00 FF FF + 256 bytes -> 256 BUS_WR cycles, addresses FFFF, 0000 .. 00FE.
- Bad opcode 0x84 x300, then a valid write -> ERR_CNT = 255, no bus strobes for the bad bytes, valid write executes normally.
- Reset mid-read (BUS_RST pulsed while RSP_VALID high) -> all outputs at reset values; the next command 00 01 00 05 77 yields a single BUS_WR to 0x0005 with data 0x77.
